// File: rtl/proc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_sequencer_if : program-load, control and processor-side signals |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface proc_sequencer_if #(
  parameter int AW = 4
) ();
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [8:0]    load_data;
  logic [AW:0]   length;
  logic          start;
  logic          done;
  logic [8:0]    instruction;
  logic          run;
  logic          busy;
  logic          finished;
  logic          error;
  logic [AW:0]   pc;
  logic [AW:0]   instr_count;

  modport master (
    input  load_en, load_addr, load_data, length, start, done,
    output instruction, run, busy, finished, error, pc, instr_count
  );

  modport slave (
    output load_en, load_addr, load_data, length, start, done,
    input  instruction, run, busy, finished, error, pc, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/proc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_sequencer : feeds a 9-bit simple processor from a program store |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module proc_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  proc_sequencer_if.master bus
);
  localparam int         WW     = $clog2(TIMEOUT + 1);
  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW:0]   pc_q, pc_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic          is_imm_q, is_imm_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          run_q, busy_q, finished_q, error_q;
  logic [8:0]    mem_q [DEPTH];

  logic [8:0]    word_w;
  logic          is_mvi_w;
  logic [AW:0]   pc_inc_w, pc_next_w;
  logic [WW-1:0] wait_inc_w;

  assign word_w     = mem_q[pc_q[AW-1:0]];
  assign is_mvi_w   = (word_w[8:6] == OP_MVI);
  assign pc_inc_w   = pc_q + {{AW{1'b0}}, 1'b1};
  assign pc_next_w  = pc_q + {{AW{1'b0}}, is_imm_q};
  assign wait_inc_w = wait_q + {{(WW-1){1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    is_imm_d = is_imm_q;
    wait_d   = wait_q;
    case (state_q)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (bus.start) begin
          cnt_d = '0;
          if (bus.length == '0) begin
            state_d = S_FINISH;
          end else begin
            len_d   = bus.length;
            pc_d    = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // An mvi in the last program slot has no immediate word to follow it.
        if (is_mvi_w && (pc_inc_w >= len_q)) begin
          state_d = S_ERROR;
        end else begin
          is_imm_d = is_mvi_w;
          pc_d     = pc_inc_w;
          wait_d   = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.done) begin
          cnt_d    = cnt_q + {{AW{1'b0}}, 1'b1};
          pc_d     = pc_next_w;
          is_imm_d = 1'b0;
          state_d  = (pc_next_w >= len_q) ? S_FINISH : S_ISSUE;
        end else begin
          wait_d = wait_inc_w;
          if (wait_inc_w == WW'(TIMEOUT)) state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      is_imm_q   <= 1'b0;
      wait_q     <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      is_imm_q   <= is_imm_d;
      wait_q     <= wait_d;
      run_q      <= (state_d == S_ISSUE);
      busy_q     <= (state_d == S_ISSUE) || (state_d == S_WAIT);
      finished_q <= (state_d == S_FINISH);
      error_q    <= (state_d == S_ERROR);
    end
  end

  // Store survives reset; writes are locked out while a program is running.
  always_ff @(posedge clk_i) begin
    if (!rst_i && bus.load_en && !busy_q) mem_q[bus.load_addr] <= bus.load_data;
  end

  assign bus.instruction = busy_q ? word_w : 9'd0;
  assign bus.run         = run_q;
  assign bus.busy        = busy_q;
  assign bus.finished    = finished_q;
  assign bus.error       = error_q;
  assign bus.pc          = pc_q;
  assign bus.instr_count = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_proc_sequencer : directed bench with a small proc model           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_proc_sequencer;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proc_sequencer_if #(.AW(AW)) bus ();

  proc_sequencer #(.DEPTH(16), .AW(AW), .TIMEOUT(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Processor model: mv/mvi complete in T1, add/sub in T3.
  logic [8:0] ir;
  logic [1:0] step;
  logic [8:0] rf [8];
  logic [8:0] acc_a, acc_g;
  logic       done_en = 1'b1;

  always_comb begin
    bus.done = done_en && (((step == 2'd1) && (ir[8:7] == 2'b00)) || (step == 2'd3));
  end

  always @(posedge clk) begin
    if (rst) begin
      step <= 2'd0;
      ir   <= 9'd0;
      for (int i = 0; i < 8; i++) rf[i] <= 9'd0;
    end else begin
      case (step)
        2'd0: if (bus.run) begin ir <= bus.instruction; step <= 2'd1; end
        2'd1: begin
          if (ir[8:6] == 3'b000) begin rf[ir[5:3]] <= rf[ir[2:0]]; step <= 2'd0; end
          else if (ir[8:6] == 3'b001) begin rf[ir[5:3]] <= bus.instruction; step <= 2'd0; end
          else begin acc_a <= rf[ir[5:3]]; step <= 2'd2; end
        end
        2'd2: begin
          acc_g <= ir[6] ? (acc_a - rf[ir[2:0]]) : (acc_a + rf[ir[2:0]]);
          step  <= 2'd3;
        end
        default: begin rf[ir[5:3]] <= acc_g; step <= 2'd0; end
      endcase
    end
  end

  logic [8:0] run_log[$];
  logic [8:0] post_log[$];
  logic       prev_run = 1'b0;

  always @(negedge clk) begin
    if (prev_run) post_log.push_back(bus.instruction);
    if (bus.run) run_log.push_back(bus.instruction);
    prev_run = bus.run;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int addr, input logic [8:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = AW'(addr);
    bus.load_data = data;
    tick();
    bus.load_en = 1'b0;
  endtask

  task automatic start_run(input int len);
    run_log.delete();
    post_log.delete();
    bus.length = (AW + 1)'(len);
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.finished || bus.error) break;
      tick();
    end
    check_value({tag, "_bound"}, 32'(bus.finished | bus.error), 32'd1);
  endtask

  initial begin
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.length  = '0;   bus.start     = 1'b0;
    repeat (3) tick();
    check_value("rst_run",  32'(bus.run), 0);
    check_value("rst_busy", 32'(bus.busy), 0);
    check_value("rst_fin",  32'(bus.finished), 0);
    check_value("rst_err",  32'(bus.error), 0);
    check_value("rst_ins",  32'(bus.instruction), 0);
    check_value("rst_pc",   32'(bus.pc), 0);
    check_value("rst_cnt",  32'(bus.instr_count), 0);
    rst = 1'b0;
    tick();

    // mvi R0,5 ; mv R1,R0 ; add R0,R1
    load_word(0, 9'b001000000);
    load_word(1, 9'b000000101);
    load_word(2, 9'b000001000);
    load_word(3, 9'b010000001);
    start_run(4);
    wait_end("basic", 60);
    check_value("basic_nrun", run_log.size(), 3);
    if (run_log.size() == 3) begin
      check_value("basic_run0", 32'(run_log[0]), 32'b001000000);
      check_value("basic_run1", 32'(run_log[1]), 32'b000001000);
      check_value("basic_run2", 32'(run_log[2]), 32'b010000001);
    end
    check_value("basic_imm", 32'(post_log.size() > 0 ? post_log[0] : 9'd0), 32'b000000101);
    check_value("basic_fin", 32'(bus.finished), 1);
    check_value("basic_pc",  32'(bus.pc), 4);
    check_value("basic_cnt", 32'(bus.instr_count), 3);
    check_value("basic_r0",  32'(rf[0]), 10);
    check_value("basic_r1",  32'(rf[1]), 5);

    // sub R0,R0 appended
    load_word(4, 9'b011000000);
    start_run(5);
    wait_end("sub", 80);
    check_value("sub_r0",  32'(rf[0]), 0);
    check_value("sub_cnt", 32'(bus.instr_count), 4);
    check_value("sub_pc",  32'(bus.pc), 5);

    // Load and Start while busy must be ignored
    start_run(5);
    bus.load_en = 1'b1; bus.load_addr = '0; bus.load_data = 9'h1FF;
    bus.start = 1'b1;   bus.length = '0;
    tick();
    bus.load_en = 1'b0; bus.start = 1'b0;
    check_value("busy_start_ign", 32'(bus.busy), 1);
    check_value("busy_not_fin",   32'(bus.finished), 0);
    wait_end("busy", 80);
    check_value("busy_cnt", 32'(bus.instr_count), 4);
    check_value("busy_r0",  32'(rf[0]), 0);

    // Reset mid-WAIT, then rerun to confirm the store is intact
    start_run(5);
    check_value("mid_issue", 32'(bus.run), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("mid_run",  32'(bus.run), 0);
    check_value("mid_busy", 32'(bus.busy), 0);
    check_value("mid_pc",   32'(bus.pc), 0);
    check_value("mid_cnt",  32'(bus.instr_count), 0);
    check_value("mid_fe",   32'(bus.finished | bus.error), 0);
    start_run(4);
    wait_end("retain", 60);
    check_value("retain_run0", 32'(run_log.size() > 0 ? run_log[0] : 9'd0), 32'b001000000);
    check_value("retain_r0",   32'(rf[0]), 10);

    // Length 0
    start_run(0);
    check_value("len0_fin", 32'(bus.finished), 1);
    check_value("len0_cnt", 32'(bus.instr_count), 0);
    tick(); tick();
    check_value("len0_nrun", run_log.size(), 0);

    // Truncated mvi
    load_word(0, 9'b001010000);
    start_run(1);
    wait_end("trunc", 10);
    check_value("trunc_err",  32'(bus.error), 1);
    check_value("trunc_nrun", run_log.size(), 1);
    check_value("trunc_pc",   32'(bus.pc), 0);
    check_value("trunc_cnt",  32'(bus.instr_count), 0);

    // Timeout with Done held low
    load_word(0, 9'b000011010);
    done_en = 1'b0;
    start_run(1);
    check_value("to_run", 32'(bus.run), 1);
    check_value("to_err_clr", 32'(bus.error), 0);
    repeat (15) tick();
    check_value("to_early", 32'(bus.error), 0);
    tick();
    check_value("to_err",  32'(bus.error), 1);
    check_value("to_nrun", run_log.size(), 1);
    done_en = 1'b1;

    // Full depth: 16 mv instructions
    for (int i = 0; i < 16; i++) load_word(i, {3'b000, 3'(i), 3'(i + 1)});
    start_run(16);
    wait_end("full", 200);
    check_value("full_nrun", run_log.size(), 16);
    check_value("full_last", 32'(run_log.size() == 16 ? run_log[15] : 9'd0), 32'b000111000);
    check_value("full_fin",  32'(bus.finished), 1);
    check_value("full_err",  32'(bus.error), 0);
    check_value("full_pc",   32'(bus.pc), 16);
    check_value("full_cnt",  32'(bus.instr_count), 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
